toccata_capture_ctrl: RTL

//  Register-level controller for the Toccata capture path: holds the capture configuration and sequences

---
 rtl/toccata_capture_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/toccata_capture_ctrl.sv
// ---------------------------------------------------------------------------
// toccata_capture_ctrl
//
// Register-level controller for the Toccata capture path. It holds the
// capture configuration, sequences start / stop / drain of the capture FIFO,
// turns CPU DATA-register reads into FIFO read strobes, detects overrun and
// raises the capture interrupt.
//
// Optional feature macro: TOCCATA_CAP_OVRCNT_EN
//   defined   -> OVRCNT is an 8-bit saturating overrun counter. Any write to
//                OVRCNT clears it.
//   undefined -> there is no counter logic, and OVRCNT reads 8'h00.
//
// Parameters
//   FIFO_SIZE      capture FIFO depth in bytes
//   DRAIN_TIMEOUT  maximum number of cycles spent in DRAIN before the block
//                  is forced back to STOP
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   bus_sel        register access strobe, one cycle long
//   bus_we         1 = write, 0 = read
//   bus_addr       register select: 0 CTRL, 1 STATUS, 2 DATA, 3 OVRCNT
//   bus_wdata      write data
//   bus_rdata      read data, valid one cycle after bus_sel
//   cap_cen        capture enable (high only in RUN)
//   cap_freq_sel   sample-rate select
//   cap_sm         0 = mono, 1 = stereo
//   cap_fmt        0 = 8-bit unsigned, 1 = 16-bit two's complement
//   cap_css        crystal select
//   cap_rd         one-cycle FIFO read strobe
//   cap_data       FIFO data output
//   cap_empty      FIFO empty flag
//   cap_half_full  FIFO half-full flag
//   cap_full       FIFO full flag
//   cap_endata     new-sample strobe from the capture block
//   irq            level interrupt, active high
// ---------------------------------------------------------------------------
module toccata_capture_ctrl #(
  parameter int FIFO_SIZE     = 1024,
  parameter int DRAIN_TIMEOUT = FIFO_SIZE + 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_sel,
  input  logic       bus_we,
  input  logic [1:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       cap_cen,
  output logic [2:0] cap_freq_sel,
  output logic       cap_sm,
  output logic       cap_fmt,
  output logic       cap_css,
  output logic       cap_rd,
  input  logic [7:0] cap_data,
  input  logic       cap_empty,
  input  logic       cap_half_full,
  input  logic       cap_full,
  input  logic       cap_endata,
  output logic       irq
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_OVR   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DATA   = 2'd2;
  localparam logic [1:0] A_OVRCNT = 2'd3;

  localparam int             CNT_W      = $clog2(DRAIN_TIMEOUT + 1);
  // The counter holds the number of DRAIN cycles already completed. The
  // cycle that sees DRAIN_TIMEOUT-1 is therefore the last one allowed.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  state_t           state, state_d;
  logic             start_pend, start_pend_d;
  logic             ovr_flag;
  logic             ie_half;
  logic [CNT_W-1:0] drain_cnt;
  logic [7:0]       ovr_cnt_rd;
  logic [7:0]       rdata_d;

  // Decoded bus transactions.
  logic ctrl_wr, stat_wr, cpu_rd, data_rd, start_wr, stop_wr;
  logic overrun, drain_done;

  assign ctrl_wr  = bus_sel & bus_we & (bus_addr == A_CTRL);
  assign stat_wr  = bus_sel & bus_we & (bus_addr == A_STATUS);
  assign cpu_rd   = bus_sel & ~bus_we;
  assign data_rd  = cpu_rd & (bus_addr == A_DATA);
  assign start_wr = ctrl_wr & bus_wdata[0];
  assign stop_wr  = ctrl_wr & ~bus_wdata[0];

  // A new sample arrives while the FIFO has no room for it.
  assign overrun    = (state == ST_RUN) & cap_endata & cap_full;
  assign drain_done = cap_empty | (drain_cnt == DRAIN_LAST);

  // A CPU read and a drain in the same cycle merge into one strobe, and
  // reading an empty FIFO never strobes.
  assign cap_rd = ~cap_empty & (data_rd | (state == ST_DRAIN));

  // Next-state logic and cap_cen.
  // NOTE: every signal assigned in this block gets a default value first. A
  // path that leaves one of them unassigned would infer a latch.
  always_comb begin
    state_d      = state;
    start_pend_d = start_pend;
    cap_cen      = 1'b0;
    unique case (state)
      ST_STOP: begin
        if (start_wr | start_pend) begin
          state_d      = ST_RUN;
          start_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        cap_cen = 1'b1;
        // An overrun takes priority over a stop written in the same cycle.
        if (overrun)      state_d = ST_OVR;
        else if (stop_wr) state_d = ST_DRAIN;
      end
      ST_OVR: begin
        if (start_wr)  start_pend_d = 1'b1;
        if (!ovr_flag) state_d      = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (start_wr)   start_pend_d = 1'b1;
        if (drain_done) state_d      = ST_STOP;
      end
      default: state_d = ST_STOP;
    endcase
  end

  // Read-data multiplexer. It is sampled into bus_rdata at the end of the
  // access cycle.
  always_comb begin
    rdata_d = 8'h00;
    unique case (bus_addr)
      A_CTRL:   rdata_d = {ie_half, cap_css, cap_fmt, cap_sm, cap_freq_sel,
                           state == ST_RUN};
      A_STATUS: rdata_d = {start_pend, state, irq, ovr_flag,
                           cap_full, cap_half_full, cap_empty};
      A_DATA:   rdata_d = cap_empty ? 8'h80 : cap_data;
      A_OVRCNT: rdata_d = ovr_cnt_rd;
      default:  rdata_d = 8'h00;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // each register sees the values that were present before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_STOP;
      start_pend   <= 1'b0;
      drain_cnt    <= '0;
      ovr_flag     <= 1'b0;
      ie_half      <= 1'b0;
      cap_freq_sel <= 3'd0;
      cap_sm       <= 1'b0;
      cap_fmt      <= 1'b0;
      cap_css      <= 1'b0;
      irq          <= 1'b0;
      bus_rdata    <= 8'h00;
    end else begin
      state      <= state_d;
      start_pend <= start_pend_d;

      if ((state == ST_DRAIN) && !drain_done) drain_cnt <= drain_cnt + 1'b1;
      else                                    drain_cnt <= '0;

      if (overrun)                       ovr_flag <= 1'b1;
      else if (stat_wr && bus_wdata[3])  ovr_flag <= 1'b0;

      // The format fields are frozen outside STOP, so the capture block never
      // sees them change mid-stream. The interrupt enable can always change.
      if (ctrl_wr) begin
        ie_half <= bus_wdata[7];
        if (state == ST_STOP) begin
          cap_freq_sel <= bus_wdata[3:1];
          cap_sm       <= bus_wdata[4];
          cap_fmt      <= bus_wdata[5];
          cap_css      <= bus_wdata[6];
        end
      end

      irq <= ovr_flag | (ie_half & cap_half_full & (state == ST_RUN));

      if (cpu_rd) bus_rdata <= rdata_d;
    end
  end

`ifdef TOCCATA_CAP_OVRCNT_EN
  logic       ovc_wr;
  logic [7:0] ovr_cnt;

  assign ovc_wr = bus_sel & bus_we & (bus_addr == A_OVRCNT);

  // A clearing write takes priority over an overrun in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             ovr_cnt <= 8'h00;
    else if (ovc_wr)                      ovr_cnt <= 8'h00;
    else if (overrun && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'h01;
  end

  assign ovr_cnt_rd = ovr_cnt;
`else
  assign ovr_cnt_rd = 8'h00;
`endif

endmodule
